// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: ALU control encodings and the multiply sequencer state type.
package legv8_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mul_state_t;

endpackage

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier controller that borrows the execute-stage ALU
// for each accumulate step and performs the operand shifts locally.
module mul_sequencer
   import legv8_pkg::*;
#(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         abort,
   input  logic [N-1:0] mcand_in,
   input  logic [N-1:0] mplr_in,
   input  logic [N-1:0] alu_result,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [3:0]   alu_ctrl,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result
);

   localparam int CW = $clog2(N);

   mul_state_t      state_q;
   logic [N-1:0]    acc_q;
   logic [N-1:0]    mcand_q;
   logic [N-1:0]    mplr_q;
   logic [CW-1:0]   cnt_q;
   logic [N-1:0]    result_q;

   logic [N-1:0]    acc_d;
   logic            lastIter;

   // The add is only kept when the current multiplier bit is set.
   always_comb begin
      acc_d    = mplr_q[0] ? alu_result : acc_q;
      lastIter = (mplr_q[N-1:1] == '0) || (cnt_q == CW'(N - 1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplr_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start && !abort) begin
                  if (mplr_in != '0) begin
                     state_q <= RUN;
                     acc_q   <= '0;
                     mcand_q <= mcand_in;
                     mplr_q  <= mplr_in;
                     cnt_q   <= '0;
                  end else begin
                     state_q  <= DONE;
                     result_q <= '0;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state_q <= IDLE;
               end else begin
                  acc_q   <= acc_d;
                  mcand_q <= mcand_q << 1;
                  mplr_q  <= mplr_q >> 1;
                  cnt_q   <= cnt_q + CW'(1);
                  if (lastIter) begin
                     state_q  <= DONE;
                     result_q <= acc_d;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Outputs are pure state decodes so that start never reaches them combinationally.
   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign alu_a    = busy ? acc_q : '0;
   assign alu_b    = busy ? mcand_q : '0;
   assign alu_ctrl = busy ? ALU_ADD : ALU_AND;
   assign result   = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed corner cases plus random
// multiplies compared against plain 64-bit arithmetic.
module tb_mul_sequencer;

   localparam int N = 64;

   logic         clk;
   logic         reset;
   logic         start;
   logic         abort;
   logic [N-1:0] mcand_in;
   logic [N-1:0] mplr_in;
   logic [N-1:0] alu_result;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [3:0]   alu_ctrl;
   logic         busy;
   logic         done;
   logic [N-1:0] result;

   int checks;
   int errors;

   mul_sequencer #(.N(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .mcand_in   (mcand_in),
      .mplr_in    (mplr_in),
      .alu_result (alu_result),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .busy       (busy),
      .done       (done),
      .result     (result)
   );

   // Stand-in for the shared execute-stage ALU that the parent owns.
   assign alu_result = (alu_ctrl == 4'b0010) ? (alu_a + alu_b) : (alu_a & alu_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Busy cycles equal one plus the index of the highest set multiplier bit.
   function automatic int expBusyCycles(input logic [N-1:0] b);
      for (int i = N - 1; i >= 0; i--)
         if (b[i]) return i + 1;
      return 0;
   endfunction

   task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
      @(negedge clk);
      start    = 1'b1;
      mcand_in = a;
      mplr_in  = b;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic waitDone(input int budget, output bit got, output int busyCnt);
      got     = 1'b0;
      busyCnt = 0;
      for (int i = 0; i < budget; i++) begin
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
         if (busy === 1'b1) begin
            busyCnt++;
            checkOutput("aluCtrlWhileBusy", N'(alu_ctrl), N'(4'b0010));
         end
         @(negedge clk);
      end
   endtask

   task automatic runMul(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
      bit got;
      int busyCnt;
      logic [N-1:0] prod;
      prod = a * b;
      applyStimulus(a, b);
      waitDone(N + 4, got, busyCnt);
      checkOutput({tag, "_donePulse"}, N'(got), N'(1));
      checkOutput({tag, "_busyCycles"}, N'(busyCnt), N'(expBusyCycles(b)));
      checkOutput({tag, "_result"}, result, prod);
      @(negedge clk);
      checkOutput({tag, "_doneOneCycle"}, N'(done), N'(0));
      checkOutput({tag, "_resultHold"}, result, prod);
      checkOutput({tag, "_aluAIdle"}, alu_a, '0);
   endtask

   initial begin
      bit got;
      int busyCnt;
      logic [N-1:0] a;
      logic [N-1:0] b;
      int width;

      checks   = 0;
      errors   = 0;
      reset    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      mcand_in = '0;
      mplr_in  = '0;

      repeat (2) @(negedge clk);
      checkOutput("resetBusy", N'(busy), N'(0));
      checkOutput("resetDone", N'(done), N'(0));
      checkOutput("resetResult", result, '0);
      checkOutput("resetAluCtrl", N'(alu_ctrl), '0);
      reset = 1'b1;

      runMul(64'd3, 64'd5, "mul3x5");
      runMul(64'd7, 64'd0, "mul7x0");
      runMul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "mulWrap");
      runMul(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, "mulFullCount");

      // A second start while running must be dropped, not queued.
      applyStimulus(64'd9, 64'd9);
      @(negedge clk);
      start    = 1'b1;
      mcand_in = 64'd2;
      mplr_in  = 64'd2;
      @(negedge clk);
      start    = 1'b0;
      waitDone(N + 4, got, busyCnt);
      checkOutput("ignoredStartDone", N'(got), N'(1));
      checkOutput("ignoredStartResult", result, 64'd81);
      @(negedge clk);
      @(negedge clk);
      checkOutput("ignoredStartNotQueued", N'(busy | done), N'(0));

      applyStimulus(64'd9, 64'd9);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abortBusy", N'(busy), N'(0));
      waitDone(N + 4, got, busyCnt);
      checkOutput("abortNoDone", N'(got), N'(0));
      checkOutput("abortResultKept", result, 64'd81);

      @(negedge clk);
      start    = 1'b1;
      abort    = 1'b1;
      mcand_in = 64'd5;
      mplr_in  = 64'd5;
      @(negedge clk);
      start    = 1'b0;
      abort    = 1'b0;
      checkOutput("abortWinsIdle", N'(busy | done), N'(0));

      applyStimulus(64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
      repeat (5) @(negedge clk);
      checkOutput("preResetBusy", N'(busy), N'(1));
      #2 reset = 1'b0;
      #1;
      checkOutput("midResetBusy", N'(busy), N'(0));
      checkOutput("midResetDone", N'(done), N'(0));
      checkOutput("midResetResult", result, '0);
      @(negedge clk);
      reset = 1'b1;
      runMul(64'd4, 64'd4, "mul4x4");

      for (int t = 0; t < 20; t++) begin
         a     = {$urandom, $urandom};
         b     = {$urandom, $urandom};
         width = $urandom_range(0, N);
         b     = (width == N) ? b : (b & ((64'd1 << width) - 64'd1));
         runMul(a, b, $sformatf("rand%0d", t));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
